// File: rtl/ofmap_requant_if.sv
// rtl/ofmap_requant_if.sv - cfg, ofmap and output handshake bundle for ofmap_requant
interface ofmap_requant_if #(
    parameter int IN_WID  = 32,
    parameter int OUT_WID = 16,
    parameter int CNT_WID = 32
);
    logic [CNT_WID+7:0] cfg_dat;
    logic               cfg_vld;
    logic               cfg_rdy;
    logic [IN_WID-1:0]  ofmap_dat;
    logic               ofmap_vld;
    logic               ofmap_rdy;
    logic [OUT_WID-1:0] out_dat;
    logic               out_vld;
    logic               out_rdy;
    logic               layer_done;
    logic               busy;

    modport master (
        output cfg_dat, cfg_vld, ofmap_dat, ofmap_vld, out_rdy,
        input  cfg_rdy, ofmap_rdy, out_dat, out_vld, layer_done, busy
    );

    modport slave (
        input  cfg_dat, cfg_vld, ofmap_dat, ofmap_vld, out_rdy,
        output cfg_rdy, ofmap_rdy, out_dat, out_vld, layer_done, busy
    );
endinterface

// File: rtl/ofmap_requant.sv
// rtl/ofmap_requant.sv - ReLU, rounding shift and 16-bit saturation of the ofmap stream with output FIFO
module ofmap_requant #(
    parameter int IN_WID     = 32,
    parameter int OUT_WID    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WID    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    ofmap_requant_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic signed [IN_WID:0] SAT_HI = {{(IN_WID-OUT_WID+2){1'b0}}, {(OUT_WID-1){1'b1}}};
    localparam logic signed [IN_WID:0] SAT_LO = {{(IN_WID-OUT_WID+2){1'b1}}, {(OUT_WID-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [CNT_WID-1:0] count_q;
    logic               relu_q;
    logic [4:0]         shift_q;
    logic [CNT_WID-1:0] in_cnt, out_cnt;
    logic [CNT_WID-1:0] in_cnt_inc, out_cnt_inc;

    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic [OUT_WID-1:0] mem [FIFO_DEPTH];
    logic               fifo_full, fifo_empty;

    logic               cfg_hs, push, pop;
    logic [CNT_WID-1:0] cfg_count;
    logic [1:0]         cfg_unused;

    logic signed [IN_WID-1:0] x_s, r_s;
    logic signed [IN_WID:0]   r_ext, rnd, sum, shd;
    logic [OUT_WID-1:0]       q_dat;

    assign cfg_count  = bus.cfg_dat[CNT_WID+7:8];
    assign cfg_unused = bus.cfg_dat[6:5];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign in_cnt_inc  = in_cnt + 1'b1;
    assign out_cnt_inc = out_cnt + 1'b1;

    assign cfg_hs = bus.cfg_vld && bus.cfg_rdy;
    assign push   = bus.ofmap_vld && bus.ofmap_rdy;
    assign pop    = bus.out_vld && bus.out_rdy;

    assign bus.out_vld = !fifo_empty;
    assign bus.out_dat = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    // Requantize the incoming word: optional ReLU, round-half-up arithmetic shift, saturate.
    always_comb begin
        x_s   = signed'(bus.ofmap_dat);
        r_s   = (relu_q && x_s < 0) ? '0 : x_s;
        r_ext = {r_s[IN_WID-1], r_s};
        rnd   = (shift_q != 5'd0) ? ((IN_WID+1)'(1) << (shift_q - 5'd1)) : '0;
        sum   = r_ext + rnd;
        shd   = sum >>> shift_q;
        if (shd > SAT_HI) begin
            q_dat = SAT_HI[OUT_WID-1:0];
        end else if (shd < SAT_LO) begin
            q_dat = SAT_LO[OUT_WID-1:0];
        end else begin
            q_dat = shd[OUT_WID-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; ofmap_rdy depends only on registered state.
    always_comb begin
        state_nxt      = state;
        bus.cfg_rdy    = 1'b0;
        bus.ofmap_rdy  = 1'b0;
        bus.layer_done = 1'b0;
        bus.busy       = 1'b1;
        case (state)
            IDLE: begin
                bus.cfg_rdy = 1'b1;
                bus.busy    = 1'b0;
                if (bus.cfg_vld) begin
                    state_nxt = (cfg_count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                bus.ofmap_rdy = !fifo_full && (in_cnt < count_q);
                if (push && (in_cnt_inc == count_q)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (out_cnt_inc == count_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.layer_done = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latched layer configuration and per-layer word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            relu_q  <= 1'b0;
            shift_q <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (cfg_hs) begin
            count_q <= cfg_count;
            relu_q  <= bus.cfg_dat[7];
            shift_q <= bus.cfg_dat[4:0];
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (push) begin
                in_cnt <= in_cnt_inc;
            end
            if (pop) begin
                out_cnt <= out_cnt_inc;
            end
        end
    end

    // FIFO pointers; reset empties the FIFO and drops any partial layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only visible while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= q_dat;
        end
    end
endmodule

// File: tb/tb_ofmap_requant.sv
// tb/tb_ofmap_requant.sv - randomized self-checking bench for ofmap_requant
module tb_ofmap_requant;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ofmap_requant_if #(.IN_WID(32), .OUT_WID(16), .CNT_WID(32)) bus ();

    ofmap_requant #(
        .IN_WID(32), .OUT_WID(16), .FIFO_DEPTH(4), .CNT_WID(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] stim_q[$];
    logic [15:0] exp_q[$];
    bit          cur_relu;
    int          cur_shift;

    function automatic logic [15:0] ref_q(input logic [31:0] x, input bit relu, input int sh);
        longint v;
        v = longint'(signed'(x));
        if (relu && v < 0) v = 0;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic do_cfg(input logic [31:0] cnt, input bit relu, input logic [4:0] sh);
        cur_relu  = relu;
        cur_shift = int'(sh);
        exp_q.delete();
        bus.cfg_dat = {cnt, relu, 2'b00, sh};
        bus.cfg_vld = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cfg_rdy !== 1'b1) begin
            failures++;
            $display("FAIL cfg_accept: cfg_rdy=%b expected 1", bus.cfg_rdy);
        end
        @(posedge clk); #1;
        bus.cfg_vld = 1'b0;
        bus.cfg_dat = '0;
    endtask

    task automatic stream(input int cnt, input int sent0, input int vld_pct, input int rdy_pct,
                          input bit strict, input string tag);
        int sent;
        int got;
        int cyc;
        bit have;
        logic [31:0] w;
        sent = sent0;
        got  = 0;
        cyc  = 0;
        have = 0;
        w    = '0;
        while (got < cnt && cyc < 5000) begin
            if (sent < cnt) begin
                if (!have) begin
                    if (stim_q.size() != 0) begin
                        w = stim_q.pop_front();
                    end else begin
                        w = $urandom;
                        if ($urandom_range(1) == 1) w = {{16{w[15]}}, w[15:0]};
                    end
                    have = 1;
                end
                bus.ofmap_vld = ($urandom_range(99) < vld_pct);
                bus.ofmap_dat = w;
            end else begin
                bus.ofmap_vld = 1'b0;
            end
            bus.out_rdy = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            checks++;
            if (bus.out_vld !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL %s out_vld: got %b expected %b", tag, bus.out_vld, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (bus.out_dat !== exp_q[0]) begin
                    failures++;
                    $display("FAIL %s out_dat: got %h expected %h", tag, bus.out_dat, exp_q[0]);
                end
            end
            checks++;
            if (bus.ofmap_rdy !== (exp_q.size() < 4 && sent < cnt)) begin
                failures++;
                $display("FAIL %s ofmap_rdy: got %b expected %b", tag, bus.ofmap_rdy,
                         exp_q.size() < 4 && sent < cnt);
            end
            checks++;
            if (bus.busy !== 1'b1 || bus.layer_done !== 1'b0) begin
                failures++;
                $display("FAIL %s busy/layer_done: got %b/%b expected 1/0", tag, bus.busy, bus.layer_done);
            end
            if (strict) begin
                checks++;
                if (bus.out_vld !== 1'b1) begin
                    failures++;
                    $display("FAIL %s throughput: out_vld=%b expected 1 at output %0d", tag, bus.out_vld, got);
                end
            end
            if (bus.out_vld && bus.out_rdy && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                got++;
            end
            if (bus.ofmap_vld && bus.ofmap_rdy) begin
                exp_q.push_back(ref_q(w, cur_relu, cur_shift));
                sent++;
                have = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.ofmap_vld = 1'b0;
        bus.out_rdy   = 1'b0;
        checks++;
        if (got < cnt) begin
            failures++;
            $display("FAIL %s timeout: got %0d words expected %0d", tag, got, cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.layer_done !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s done_pulse: layer_done/busy=%b/%b expected 1/1", tag, bus.layer_done, bus.busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.layer_done !== 1'b0 || bus.cfg_rdy !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s back_to_idle: layer_done/cfg_rdy/busy=%b/%b/%b expected 0/1/0",
                     tag, bus.layer_done, bus.cfg_rdy, bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.cfg_rdy !== 1'b1 || bus.ofmap_rdy !== 1'b0 || bus.out_vld !== 1'b0 ||
            bus.out_dat !== 16'h0 || bus.layer_done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: cfg_rdy=%b ofmap_rdy=%b out_vld=%b out_dat=%h layer_done=%b busy=%b expected 1 0 0 0000 0 0",
                     bus.cfg_rdy, bus.ofmap_rdy, bus.out_vld, bus.out_dat, bus.layer_done, bus.busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rounding();
        do_cfg(32'd2, 1'b0, 5'd4);
        stim_q = '{32'h0000_0118, 32'hFFFF_FEE8};
        stream(2, 0, 100, 100, 0, "rounding");
    endtask

    task automatic test_saturation();
        do_cfg(32'd3, 1'b0, 5'd0);
        stim_q = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_1234};
        stream(3, 0, 100, 60, 0, "saturation");
    endtask

    task automatic test_relu();
        do_cfg(32'd2, 1'b1, 5'd1);
        stim_q = '{32'hFFFF_FFFB, 32'h0000_0005};
        stream(2, 0, 100, 100, 0, "relu");
    endtask

    task automatic test_backpressure();
        logic [31:0] words[6];
        logic [15:0] held;
        int sent;
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        do_cfg(32'd6, 1'b0, 5'd3);
        sent = 0;
        held = '0;
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.ofmap_vld = (sent < 6);
            bus.ofmap_dat = words[sent < 6 ? sent : 5];
            @(negedge clk);
            if (sent == 1) held = bus.out_dat;
            if (bus.ofmap_vld && bus.ofmap_rdy) begin
                exp_q.push_back(ref_q(words[sent], cur_relu, cur_shift));
                sent++;
            end
            @(posedge clk); #1;
        end
        bus.ofmap_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (sent != 4 || bus.ofmap_rdy !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall: accepted=%0d ofmap_rdy=%b expected 4 and 0", sent, bus.ofmap_rdy);
        end
        checks++;
        if (bus.out_dat !== held || bus.out_dat !== ref_q(words[0], 1'b0, 3)) begin
            failures++;
            $display("FAIL bp_hold: out_dat=%h earlier=%h expected %h", bus.out_dat, held,
                     ref_q(words[0], 1'b0, 3));
        end
        @(posedge clk); #1;
        stim_q = '{words[4], words[5]};
        stream(6, 4, 100, 100, 1, "backpressure");
    endtask

    task automatic test_count_zero();
        do_cfg(32'd0, 1'b0, 5'd0);
        @(negedge clk);
        checks++;
        if (bus.layer_done !== 1'b1 || bus.ofmap_rdy !== 1'b0) begin
            failures++;
            $display("FAIL count0_done: layer_done=%b ofmap_rdy=%b expected 1 0", bus.layer_done, bus.ofmap_rdy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.layer_done !== 1'b0 || bus.cfg_rdy !== 1'b1) begin
            failures++;
            $display("FAIL count0_idle: layer_done=%b cfg_rdy=%b expected 0 1", bus.layer_done, bus.cfg_rdy);
        end
        @(posedge clk); #1;
        do_cfg(32'd3, 1'b0, 5'd2);
        bus.cfg_dat = {32'd0, 1'b1, 2'b00, 5'd9};
        bus.cfg_vld = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cfg_rdy !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL cfg_ignored: cfg_rdy=%b busy=%b expected 0 1", bus.cfg_rdy, bus.busy);
        end
        @(posedge clk); #1;
        bus.cfg_vld = 1'b0;
        bus.cfg_dat = '0;
        stream(3, 0, 100, 100, 0, "cfg_ignored_layer");
    endtask

    task automatic test_reset_mid();
        int sent;
        int c;
        do_cfg(32'd8, 1'b0, 5'd0);
        sent = 0;
        c = 0;
        bus.out_rdy = 1'b0;
        while (sent < 3 && c < 20) begin
            bus.ofmap_vld = 1'b1;
            bus.ofmap_dat = $urandom;
            @(negedge clk);
            if (bus.ofmap_vld && bus.ofmap_rdy) sent++;
            @(posedge clk); #1;
            c++;
        end
        bus.ofmap_vld = 1'b0;
        checks++;
        if (sent != 3 || bus.out_vld !== 1'b1) begin
            failures++;
            $display("FAIL mid_prefill: accepted=%0d out_vld=%b expected 3 1", sent, bus.out_vld);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.ofmap_rdy !== 1'b0 || bus.cfg_rdy !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: out_vld=%b ofmap_rdy=%b cfg_rdy=%b busy=%b expected 0 0 1 0",
                     bus.out_vld, bus.ofmap_rdy, bus.cfg_rdy, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        stim_q.delete();
        do_cfg(32'd1, 1'b0, 5'd5);
        stream(1, 0, 100, 100, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int l = 0; l < 8; l++) begin
            stim_q.delete();
            do_cfg(32'($urandom_range(1, 20)), 1'($urandom_range(1)), 5'($urandom_range(0, 31)));
            stream(int'(dut.count_q), 0, $urandom_range(30, 100), $urandom_range(20, 100), 0, "random");
        end
    endtask

    initial begin
        bus.cfg_dat   = '0;
        bus.cfg_vld   = 1'b0;
        bus.ofmap_dat = '0;
        bus.ofmap_vld = 1'b0;
        bus.out_rdy   = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_relu();
        test_backpressure();
        test_count_zero();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
